// File: rtl/hsv_core_mem_dmem_rd_arbiter.sv
// hsv_core_mem_dmem_rd_arbiter
// Two-requester read arbiter in front of a shared AXI data-memory read port.
// The AR channel leaves through a single register stage. An in-order ID FIFO
// remembers which requester owns each outstanding read, and the shared R
// channel is routed back to the requester at the FIFO head.
// Optional build macro: HSV_CORE_DMEM_ARB_FIXED_PRIO_EN. When it is defined,
// port 0 always wins and there is no last-granted pointer. Without it,
// arbitration is round-robin.
module hsv_core_mem_dmem_rd_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic                           clk_core,
   input  logic                           rst_core,
   input  logic [1:0]                     req_ar_valid,
   input  logic [1:0][31:0]               req_ar_addr,
   output logic [1:0]                     req_ar_ready,
   output logic [1:0]                     req_r_valid,
   output logic [31:0]                    req_r_data,
   output logic [1:0]                     req_r_resp,
   input  logic [1:0]                     req_r_ready,
   output logic                           dmem_ar_valid,
   output logic [31:0]                    dmem_ar_addr,
   input  logic                           dmem_ar_ready,
   input  logic                           dmem_r_valid,
   input  logic [31:0]                    dmem_r_data,
   input  logic [1:0]                     dmem_r_resp,
   output logic                           dmem_r_ready,
   output logic [$clog2(DEPTH+1)-1:0]     outstanding
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic             winner;
   logic             stage_free;
   logic             grant_ok;
   logic             grant;
   logic             pop;
   logic             empty;
   logic             head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             fifo_id [DEPTH];

`ifdef HSV_CORE_DMEM_ARB_FIXED_PRIO_EN
   // Fixed priority: port 0 wins whenever it is valid.
   always_comb begin
      winner = ~req_ar_valid[0];
   end
`else
   logic last_grant;

   // Round-robin: on a tie the port not granted last wins; otherwise the only valid port wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so that no path can infer a latch.
      winner = 1'b0;
      if (&req_ar_valid) winner = ~last_grant;
      else               winner = req_ar_valid[1];
   end

   // The last-granted pointer moves only when a grant is made. Its reset value of 1 lets port 0 win first.
   always_ff @(posedge clk_core or posedge rst_core) begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      if (rst_core)   last_grant <= 1'b1;
      else if (grant) last_grant <= winner;
   end
`endif

   // The grant is qualified by a free stage and a non-full tracker. It uses the count before any same-cycle pop.
   always_comb begin
      stage_free   = ~dmem_ar_valid | dmem_ar_ready;
      grant_ok     = stage_free & (outstanding < CNT_W'(DEPTH));
      req_ar_ready = '0;
      if (grant_ok && (|req_ar_valid)) req_ar_ready[winner] = 1'b1;
      grant        = |req_ar_ready;
   end

   // AR register stage: load on grant, hold until the slave accepts, and clear after an accept with no refill.
   always_ff @(posedge clk_core or posedge rst_core) begin
      if (rst_core) begin
         dmem_ar_valid <= 1'b0;
         dmem_ar_addr  <= '0;
      end else if (grant) begin
         dmem_ar_valid <= 1'b1;
         dmem_ar_addr  <= req_ar_addr[winner];
      end else if (dmem_ar_ready) begin
         dmem_ar_valid <= 1'b0;
      end
   end

   // ID FIFO storage: a grant writes the winner's ID at the write pointer.
   always_ff @(posedge clk_core) begin
      // NOTE: the storage array has no reset. The pointers and the count alone decide which entries are valid.
      if (grant) fifo_id[wr_ptr] <= winner;
   end

   // FIFO pointers advance on a push or pop. They wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_core or posedge rst_core) begin
      if (rst_core) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (grant) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // The outstanding count doubles as the FIFO occupancy. A push and a pop in the same cycle cancel out.
   always_ff @(posedge clk_core or posedge rst_core) begin
      if (rst_core) begin
         outstanding <= '0;
      end else begin
         case ({grant, pop})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // R routing: the beat goes to the FIFO-head owner. Stray beats with nothing outstanding are never accepted.
   always_comb begin
      empty        = (outstanding == '0);
      head         = fifo_id[rd_ptr];
      req_r_valid  = '0;
      if (!empty && dmem_r_valid) req_r_valid[head] = 1'b1;
      dmem_r_ready = ~empty & req_r_ready[head];
      pop          = dmem_r_valid & dmem_r_ready;
      req_r_data   = dmem_r_data;
      req_r_resp   = dmem_r_resp;
   end

endmodule
